// File: rtl/lms_pkg.sv
// Shared constants and helpers for the LMS error controller.
package lms_pkg;

  // Controller FSM encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KICK = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  // Working width for saturation; every operand is sign-extended to this first
  localparam int SAT_MAX_W = 64;

  // Clamp a sign-extended value to the signed range of an ow-bit result
  function automatic logic signed [SAT_MAX_W-1:0] sat_fn(
    input logic signed [SAT_MAX_W-1:0] v,
    input int                          ow
  );
    logic signed [SAT_MAX_W-1:0] hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lms_sat_shift.sv
// Arithmetic right shift (floor) followed by signed saturation.
module lms_sat_shift
  import lms_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int SH    = 0,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [SAT_MAX_W-1:0] ext, shd, sat;

  // Widen, shift toward -inf, then clamp to the output range
  always_comb begin
    ext  = $signed({{(SAT_MAX_W-IN_W){din[IN_W-1]}}, din});
    shd  = ext >>> SH;
    sat  = sat_fn(shd, OUT_W);
    dout = sat[OUT_W-1:0];
  end

endmodule

// File: rtl/lms_err_ctrl.sv
// Sample-rate controller: kicks the LMS filter, waits for its result,
// forms e = d - y, feeds the step-scaled error back and streams e out.
module lms_err_ctrl
  import lms_pkg::*;
#(
  parameter int X_W    = 16,
  parameter int D_W    = 16,
  parameter int Y_W    = 16,
  parameter int E_W    = 16,
  parameter int MU_SH  = 4,
  parameter int TO_CYC = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [X_W-1:0] s_x,
  input  logic [D_W-1:0] s_d,
  input  logic           adapt_en,
  output logic           lms_en,
  output logic [X_W-1:0] lms_xin,
  output logic [E_W-1:0] lms_err,
  input  logic           lms_update,
  input  logic [Y_W-1:0] lms_yout,
  output logic           e_valid,
  input  logic           e_ready,
  output logic [Y_W-1:0] e_out,
  output logic           to_err
);

  // Difference width never overflows: one bit above the wider operand
  localparam int EI_W  = ((D_W > Y_W) ? D_W : Y_W) + 1;
  localparam int CNT_W = $clog2(TO_CYC) + 1;

  logic [2:0]       state_q, state_d;
  logic [X_W-1:0]   xin_q, xin_d;
  logic [D_W-1:0]   d_q, d_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [E_W-1:0]   err_q, err_d;
  logic [Y_W-1:0]   eo_q, eo_d;
  logic             ev_q, ev_d;
  logic             to_q, to_d;
  logic             rdy_q, rdy_d;
  logic             en_q, en_d;

  logic signed [EI_W-1:0] e_raw;
  logic signed [Y_W-1:0]  e_sat;
  logic signed [E_W-1:0]  err_sat;

  assign e_raw = $signed({{(EI_W-D_W){d_q[D_W-1]}}, d_q})
               - $signed({{(EI_W-Y_W){y_q[Y_W-1]}}, y_q});

  lms_sat_shift #(.IN_W(EI_W), .SH(0), .OUT_W(Y_W)) u_sat_e (
    .din (e_raw),
    .dout(e_sat)
  );

  lms_sat_shift #(.IN_W(EI_W), .SH(MU_SH), .OUT_W(E_W)) u_sat_err (
    .din (e_raw),
    .dout(err_sat)
  );

  // Next-state and datapath update; s_ready/lms_en are registered decodes of the next state
  always_comb begin
    state_d = state_q;
    xin_d   = xin_q;
    d_d     = d_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    eo_d    = eo_q;
    ev_d    = ev_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (s_valid && rdy_q) begin
          xin_d   = s_x;
          d_d     = s_d;
          state_d = S_KICK;
        end
      end
      S_KICK: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // An update on the terminal cycle still counts as success
        if (lms_update) begin
          y_d     = lms_yout;
          state_d = S_CALC;
        end else if (cnt_d == CNT_W'(TO_CYC - 1)) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        eo_d    = e_sat;
        err_d   = adapt_en ? err_sat : '0;
        ev_d    = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (e_ready) begin
          ev_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
    en_d  = (state_d == S_KICK);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      xin_q   <= '0;
      d_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      eo_q    <= '0;
      ev_q    <= 1'b0;
      to_q    <= 1'b0;
      rdy_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xin_q   <= xin_d;
      d_q     <= d_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      eo_q    <= eo_d;
      ev_q    <= ev_d;
      to_q    <= to_d;
      rdy_q   <= rdy_d;
      en_q    <= en_d;
    end
  end

  assign s_ready = rdy_q;
  assign lms_en  = en_q;
  assign lms_xin = xin_q;
  assign lms_err = err_q;
  assign e_valid = ev_q;
  assign e_out   = eo_q;
  assign to_err  = to_q;

endmodule
